// File: rtl/synth_pkg.sv
// Shared types and constants for the synth voice path.
package synth_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ATTACK  = 3'd1,
      DECAY   = 3'd2,
      SUSTAIN = 3'd3,
      RELEASE = 3'd4
   } env_state_t;

   localparam int ENV_MAX = 255;
   localparam int FS_HZ   = 8000;

endpackage

// File: rtl/env_scaler.sv
// Registered sample-by-envelope multiply. Zero envelope gives silence, and full scale
// passes the sample through unchanged.
module env_scaler #(
   parameter int SAMPLE_W = 9,
   parameter int ENV_W    = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [SAMPLE_W-1:0] sample,
   input  logic [ENV_W-1:0]    env,
   output logic [SAMPLE_W-1:0] scaled
);

   localparam int PROD_W = SAMPLE_W + ENV_W + 1;

   logic [ENV_W:0]        env_p1_s;
   logic [PROD_W-1:0]     prod_s;
   logic [SAMPLE_W-1:0]   scaled_s;
   logic [SAMPLE_W-1:0]   scaled_r;

   // Multiply by env+1 so that env=ENV_MAX maps to a pure shift of the input.
   always_comb begin
      env_p1_s = {1'b0, env} + {{ENV_W{1'b0}}, 1'b1};
      prod_s   = {{(ENV_W + 1){1'b0}}, sample} * {{SAMPLE_W{1'b0}}, env_p1_s};
      if (env == {ENV_W{1'b0}}) begin
         scaled_s = {SAMPLE_W{1'b0}};
      end else begin
         scaled_s = SAMPLE_W'(prod_s >> ENV_W);
      end
   end

   // Output register, updated every clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scaled_r <= {SAMPLE_W{1'b0}};
      end else begin
         scaled_r <= scaled_s;
      end
   end

   assign scaled = scaled_r;

endmodule

// File: rtl/adsr_envelope.sv
// ADSR envelope generator stepping at the sample rate, scaling both sine half-waves.
// A retrigger restarts ATTACK from the current level so note changes do not click.
module adsr_envelope
   import synth_pkg::*;
#(
   parameter int SAMPLE_W      = 9,
   parameter int ENV_W         = 8,
   parameter int ATTACK_STEP   = 32,
   parameter int DECAY_STEP    = 8,
   parameter int SUSTAIN_LEVEL = 192,
   parameter int RELEASE_STEP  = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                fs_tick,
   input  logic                gate,
   input  logic                note_start,
   input  logic [SAMPLE_W-1:0] pos_in,
   input  logic [SAMPLE_W-1:0] neg_in,
   output logic [SAMPLE_W-1:0] pos_out,
   output logic [SAMPLE_W-1:0] neg_out,
   output logic [ENV_W-1:0]    env_level,
   output logic                active
);

   localparam int ENV_TOP = (1 << ENV_W) - 1;

   localparam logic [ENV_W:0]   attack_step_c  = (ENV_W + 1)'(ATTACK_STEP);
   localparam logic [ENV_W:0]   decay_step_c   = (ENV_W + 1)'(DECAY_STEP);
   localparam logic [ENV_W:0]   release_step_c = (ENV_W + 1)'(RELEASE_STEP);
   localparam logic [ENV_W-1:0] sustain_c      = ENV_W'(SUSTAIN_LEVEL);
   localparam logic [ENV_W-1:0] env_max_c      = {ENV_W{1'b1}};

   if (ATTACK_STEP < 1 || ATTACK_STEP > ENV_TOP ||
       DECAY_STEP < 1 || DECAY_STEP > ENV_TOP ||
       RELEASE_STEP < 1 || RELEASE_STEP > ENV_TOP ||
       SUSTAIN_LEVEL < 0 || SUSTAIN_LEVEL > ENV_TOP ||
       (ENV_W == 8 && ENV_TOP != ENV_MAX)) begin : g_bad_param
      $error("adsr_envelope: step/sustain parameter out of range");
   end

   env_state_t       state_r;
   env_state_t       next_state_s;
   logic [ENV_W-1:0] env_r;
   logic [ENV_W-1:0] next_env_s;
   logic             pend_r;
   logic             active_r;
   logic             retrig_s;
   logic [ENV_W:0]   sum_s;
   logic [ENV_W:0]   dec_s;
   logic [ENV_W:0]   rel_s;

   // Next-state and next-level decision, applied only on fs_tick.
   always_comb begin
      retrig_s     = pend_r | note_start;
      sum_s        = {1'b0, env_r} + attack_step_c;
      dec_s        = {1'b0, env_r} - decay_step_c;
      rel_s        = {1'b0, env_r} - release_step_c;
      next_state_s = state_r;
      next_env_s   = env_r;
      if (retrig_s) begin
         next_state_s = ATTACK;
      end else begin
         case (state_r)
            IDLE: begin
               if (gate) begin
                  next_state_s = ATTACK;
               end else begin
                  next_state_s = IDLE;
               end
            end
            ATTACK: begin
               if (!gate) begin
                  next_state_s = RELEASE;
               end else if (sum_s >= {1'b0, env_max_c}) begin
                  next_env_s   = env_max_c;
                  next_state_s = DECAY;
               end else begin
                  next_env_s   = sum_s[ENV_W-1:0];
               end
            end
            DECAY: begin
               // dec_s[ENV_W] is the borrow; any borrow clamps at the sustain level.
               if (!gate) begin
                  next_state_s = RELEASE;
               end else if (dec_s[ENV_W] || (dec_s[ENV_W-1:0] <= sustain_c)) begin
                  next_env_s   = sustain_c;
                  next_state_s = SUSTAIN;
               end else begin
                  next_env_s   = dec_s[ENV_W-1:0];
               end
            end
            SUSTAIN: begin
               if (!gate) begin
                  next_state_s = RELEASE;
               end else begin
                  next_state_s = SUSTAIN;
               end
            end
            RELEASE: begin
               if (gate) begin
                  next_state_s = ATTACK;
               end else if (rel_s[ENV_W] || (rel_s[ENV_W-1:0] == {ENV_W{1'b0}})) begin
                  next_env_s   = {ENV_W{1'b0}};
                  next_state_s = IDLE;
               end else begin
                  next_env_s   = rel_s[ENV_W-1:0];
               end
            end
            default: begin
               next_state_s = IDLE;
               next_env_s   = {ENV_W{1'b0}};
            end
         endcase
      end
   end

   // Envelope FSM, level, active flag and retrigger latch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r  <= IDLE;
         env_r    <= {ENV_W{1'b0}};
         active_r <= 1'b0;
         pend_r   <= 1'b0;
      end else if (fs_tick) begin
         state_r  <= next_state_s;
         env_r    <= next_env_s;
         active_r <= (next_state_s != IDLE);
         pend_r   <= 1'b0;
      end else if (note_start) begin
         pend_r   <= 1'b1;
      end else begin
         pend_r   <= pend_r;
      end
   end

   env_scaler #(.SAMPLE_W(SAMPLE_W), .ENV_W(ENV_W)) u_pos_scaler (
      .clk    (clk),
      .reset  (reset),
      .sample (pos_in),
      .env    (env_r),
      .scaled (pos_out)
   );

   env_scaler #(.SAMPLE_W(SAMPLE_W), .ENV_W(ENV_W)) u_neg_scaler (
      .clk    (clk),
      .reset  (reset),
      .sample (neg_in),
      .env    (env_r),
      .scaled (neg_out)
   );

   assign env_level = env_r;
   assign active    = active_r;

endmodule
